// File: rtl/ssm_funnel_shifter.sv
// Substream funnel shifter: buffers DW-bit codec words MSB-first, exposes a WIN-bit peek
// window and drops a variable number of bits (plus optional alignment skip) per consume.
module ssm_funnel_shifter #(
    parameter  int DW    = 128,
    parameter  int WIN   = 128,
    parameter  int ALIGN = 8,
    parameter  int CAP   = DW + WIN,
    parameter  int POSW  = 32,
    localparam int FW    = $clog2(CAP + 1),
    localparam int CLW   = $clog2(WIN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [DW-1:0]   in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [WIN-1:0]  win_data,
    output logic            win_valid,
    output logic [FW-1:0]   fullness,
    input  logic            consume_en,
    input  logic [CLW-1:0]  consume_len,
    input  logic            align_en,
    output logic [POSW-1:0] bit_pos,
    output logic            err_underflow
);

    logic [CAP-1:0]  r_buf;
    logic [FW-1:0]   r_full;
    logic [POSW-1:0] r_pos;
    logic            r_err;

    logic            w_accept;
    logic            w_cons_ok;
    logic            w_bad;
    logic [FW-1:0]   w_len;
    logic [FW-1:0]   w_skip;
    logic [FW:0]     w_need;
    logic [FW-1:0]   w_drop;
    logic [FW-1:0]   w_keep;
    logic [POSW-1:0] w_pos_l;
    logic [CAP-1:0]  w_word;

    assign win_data      = r_buf[CAP-1 -: WIN];
    assign win_valid     = (r_full >= FW'(WIN));
    assign in_ready      = (r_full <= FW'(CAP - DW));
    assign fullness      = r_full;
    assign bit_pos       = r_pos;
    assign err_underflow = r_err;

    assign w_accept  = in_valid & in_ready;
    assign w_cons_ok = consume_en & win_valid & (consume_len <= CLW'(WIN));
    assign w_len     = w_cons_ok ? FW'(consume_len) : '0;

    // Skip distance to the next ALIGN boundary after the consumed bits (ALIGN is a power of 2).
    assign w_pos_l = r_pos + POSW'(w_len);
    assign w_skip  = (align_en & (w_cons_ok | ~consume_en))
                   ? FW'((-w_pos_l) & POSW'(ALIGN - 1)) : '0;

    // Any illegal part drops the whole request; only the error flag is affected.
    assign w_need = {1'b0, w_len} + {1'b0, w_skip};
    assign w_bad  = (consume_en & ~w_cons_ok) | (w_need > {1'b0, r_full});
    assign w_drop = w_bad ? '0 : w_need[FW-1:0];
    assign w_keep = r_full - w_drop;

    // New word lands directly behind the bits that survive this cycle's drop.
    assign w_word = {in_data, {(CAP - DW){1'b0}}} >> w_keep;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_buf  <= '0;
            r_full <= '0;
            r_pos  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_buf  <= (r_buf << w_drop) | (w_accept ? w_word : '0);
            r_full <= w_keep + (w_accept ? FW'(DW) : '0);
            r_pos  <= r_pos + POSW'(w_drop);
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ssm_funnel_shifter.sv
// Bench for ssm_funnel_shifter: directed vector table, bit-queue reference model under random
// stimulus, and a narrow-POSW instance for bit_pos wrap.
module tb_ssm_funnel_shifter;

    logic         clk;
    logic         rst, flush, in_valid, in_ready, win_valid, consume_en, align_en, err_underflow;
    logic [127:0] in_data, win_data;
    logic [8:0]   fullness;
    logic [7:0]   consume_len;
    logic [31:0]  bit_pos;

    logic         s_rst, s_flush, s_vin, s_ir, s_wv, s_ce, s_ae, s_err;
    logic [127:0] s_d, s_win;
    logic [8:0]   s_full;
    logic [7:0]   s_len;
    logic [7:0]   s_pos;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    ssm_funnel_shifter u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .win_data(win_data), .win_valid(win_valid), .fullness(fullness),
        .consume_en(consume_en), .consume_len(consume_len), .align_en(align_en),
        .bit_pos(bit_pos), .err_underflow(err_underflow)
    );

    ssm_funnel_shifter #(.DW(128), .WIN(128), .ALIGN(8), .POSW(8)) u_small (
        .clk(clk), .rst(s_rst), .flush(s_flush), .in_data(s_d), .in_valid(s_vin),
        .in_ready(s_ir), .win_data(s_win), .win_valid(s_wv), .fullness(s_full),
        .consume_en(s_ce), .consume_len(s_len), .align_en(s_ae),
        .bit_pos(s_pos), .err_underflow(s_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           r, fl, vin;
        logic [127:0] d;
        bit           ce;
        int unsigned  len;
        bit           ae;
        int unsigned  e_full;
        logic [31:0]  e_pos;
        bit           e_err, e_wv, e_ir;
        logic [127:0] e_win;
    } vec_t;

    vec_t tbl[$];

    // Reference model: stream held as a queue of bits, head = next bit.
    bit              mq[$];
    longint unsigned mpos;
    bit              merr;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    function automatic vec_t mk(input bit r, fl, vin, input logic [127:0] d, input bit ce,
                                input int unsigned len, input bit ae, input int unsigned f,
                                input int unsigned pos, input bit err, input logic [127:0] w);
        vec_t v;
        v.r = r; v.fl = fl; v.vin = vin; v.d = d; v.ce = ce; v.len = len; v.ae = ae;
        v.e_full = f; v.e_pos = pos; v.e_err = err;
        v.e_wv = (f >= 128); v.e_ir = (f <= 128); v.e_win = w;
        return v;
    endfunction

    task automatic apply(input bit r, fl, vin, input logic [127:0] d, input bit ce,
                         input int unsigned len, input bit ae);
        rst = r; flush = fl; in_valid = vin; in_data = d;
        consume_en = ce; consume_len = 8'(len); align_en = ae;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; consume_en = 1'b0; align_en = 1'b0;
    endtask

    task automatic model_step(input bit r, fl, vin, input logic [127:0] d, input bit ce,
                              input int unsigned len, input bit ae);
        int unsigned full, l, s;
        bit ok, bad, acc;
        if (r || fl) begin
            mq.delete(); mpos = 0; merr = 1'b0;
            return;
        end
        full = mq.size();
        acc  = vin && (full + 128 <= 256);
        ok   = ce && (full >= 128) && (len <= 128);
        l    = ok ? len : 0;
        s    = 0;
        if (ae && (ok || !ce)) s = (8 - ((mpos + l) % 8)) % 8;
        bad  = (ce && !ok) || (l + s > full);
        if (bad) merr = 1'b1;
        else begin
            repeat (l + s) void'(mq.pop_front());
            mpos = (mpos + l + s) % (64'd1 << 32);
        end
        if (acc) for (int i = 127; i >= 0; i--) mq.push_back(d[i]);
    endtask

    function automatic logic [127:0] model_win();
        logic [127:0] w;
        w = '0;
        for (int i = 0; i < 128 && i < mq.size(); i++) w[127-i] = mq[i];
        return w;
    endfunction

    initial begin
        logic [127:0] A, P, Q, R, T, Z;
        A = 128'hFFFF_0000_0000_0000_0000_0000_0000_0000;
        P = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        Q = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1234_5678;
        R = 128'hA5C3_96E1_0F1E_2D3C_4B5A_6978_8796_A5B4;
        T = 128'h5555_AAAA_3333_CCCC_0F0F_F0F0_00FF_FF00;
        Z = '0;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        consume_en = 1'b0; consume_len = '0; align_en = 1'b0;
        s_rst = 1'b0; s_flush = 1'b0; s_vin = 1'b0; s_d = '0;
        s_ce = 1'b0; s_len = '0; s_ae = 1'b0;

        //               r fl vin d  ce len ae  full pos err win
        tbl.push_back(mk(1, 0, 0, Z, 0,   0, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, A, 0,   0, 0, 128,   0, 0, A));
        tbl.push_back(mk(0, 1, 0, Z, 0,   0, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, P, 0,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(0, 0, 1, Q, 0,   0, 0, 256,   0, 0, P));
        tbl.push_back(mk(0, 0, 0, Z, 1,  37, 0, 219,  37, 0, {P[90:0], Q[127:91]}));
        tbl.push_back(mk(0, 0, 0, Z, 1,  91, 0, 128, 128, 0, Q));
        tbl.push_back(mk(0, 0, 1, R, 1, 100, 0, 156, 228, 0, {Q[27:0], R[127:28]}));
        tbl.push_back(mk(0, 0, 1, T, 0,   0, 0, 156, 228, 0, {Q[27:0], R[127:28]}));
        tbl.push_back(mk(0, 1, 0, Z, 0,   0, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, P, 0,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(0, 0, 1, Q, 0,   0, 0, 256,   0, 0, P));
        tbl.push_back(mk(0, 0, 0, Z, 1,  37, 0, 219,  37, 0, {P[90:0], Q[127:91]}));
        tbl.push_back(mk(0, 0, 0, Z, 1,   3, 1, 216,  40, 0, {P[87:0], Q[127:88]}));
        tbl.push_back(mk(0, 0, 0, Z, 1,   5, 1, 208,  48, 0, {P[79:0], Q[127:80]}));
        tbl.push_back(mk(0, 1, 0, Z, 0,   0, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, P, 0,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(0, 0, 0, Z, 1,  64, 0,  64,  64, 0, {P[63:0], 64'h0}));
        tbl.push_back(mk(0, 0, 0, Z, 1,  10, 0,  64,  64, 1, {P[63:0], 64'h0}));
        tbl.push_back(mk(0, 0, 0, Z, 0,   0, 0,  64,  64, 1, {P[63:0], 64'h0}));
        tbl.push_back(mk(0, 1, 0, Z, 0,   0, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, P, 0,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(0, 0, 0, Z, 1, 129, 0, 128,   0, 1, P));
        tbl.push_back(mk(0, 1, 0, Z, 0,   0, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, P, 0,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(0, 0, 0, Z, 1,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(0, 0, 0, Z, 1,  61, 0,  67,  61, 0, {P[66:0], 61'h0}));
        tbl.push_back(mk(0, 0, 0, Z, 0,   0, 1,  64,  64, 0, {P[63:0], 64'h0}));
        tbl.push_back(mk(0, 0, 0, Z, 1,   8, 1,  64,  64, 1, {P[63:0], 64'h0}));
        tbl.push_back(mk(0, 1, 1, P, 1,   8, 0,   0,   0, 0, Z));
        tbl.push_back(mk(0, 0, 1, P, 0,   0, 0, 128,   0, 0, P));
        tbl.push_back(mk(1, 0, 1, Q, 1,   8, 1,   0,   0, 0, Z));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].fl, tbl[i].vin, tbl[i].d, tbl[i].ce, tbl[i].len, tbl[i].ae);
            chk($sformatf("vec%0d.fullness", i), fullness, tbl[i].e_full);
            chk($sformatf("vec%0d.bit_pos", i), bit_pos, tbl[i].e_pos);
            chk($sformatf("vec%0d.err", i), err_underflow, tbl[i].e_err);
            chk($sformatf("vec%0d.win_valid", i), win_valid, tbl[i].e_wv);
            chk($sformatf("vec%0d.in_ready", i), in_ready, tbl[i].e_ir);
            chk($sformatf("vec%0d.win_data", i), win_data, tbl[i].e_win);
        end

        // Randomized run against the bit-queue model; DUT was just reset by the last vector.
        mq.delete(); mpos = 0; merr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            bit           r, fl, vin, ce, ae;
            logic [127:0] d;
            int unsigned  len;
            r   = ($urandom_range(0, 199) == 0);
            fl  = ($urandom_range(0, 99) == 0);
            vin = ($urandom_range(0, 9) < 6);
            d   = {$urandom, $urandom, $urandom, $urandom};
            ce  = ($urandom_range(0, 1) == 1);
            len = ($urandom_range(0, 19) == 0) ? $urandom_range(129, 255) : $urandom_range(0, 128);
            ae  = ($urandom_range(0, 3) == 0);
            apply(r, fl, vin, d, ce, len, ae);
            model_step(r, fl, vin, d, ce, len, ae);
            chk($sformatf("rnd%0d.fullness", c), fullness, mq.size());
            chk($sformatf("rnd%0d.bit_pos", c), bit_pos, mpos[31:0]);
            chk($sformatf("rnd%0d.err", c), err_underflow, merr);
            chk($sformatf("rnd%0d.win_valid", c), win_valid, mq.size() >= 128);
            chk($sformatf("rnd%0d.in_ready", c), in_ready, mq.size() <= 128);
            chk($sformatf("rnd%0d.win_data", c), win_data, model_win());
        end

        // bit_pos wrap on an 8-bit counter: stream P,Q,P; consume 128,124,8 -> 4 after wrap.
        s_rst = 1'b1;
        @(posedge clk); #1;
        s_rst = 1'b0;
        s_vin = 1'b1; s_d = P;
        @(posedge clk); #1;
        chk("wrap.full0", s_full, 128);
        s_ce = 1'b1; s_len = 8'd128; s_d = Q;
        @(posedge clk); #1;
        chk("wrap.pos1", s_pos, 128);
        s_len = 8'd124; s_d = P;
        @(posedge clk); #1;
        chk("wrap.pos2", s_pos, 252);
        chk("wrap.full2", s_full, 132);
        s_vin = 1'b0; s_len = 8'd8;
        @(posedge clk); #1;
        s_ce = 1'b0;
        chk("wrap.pos3", s_pos, 4);
        chk("wrap.full3", s_full, 124);
        chk("wrap.win3", s_win, {P[123:0], 4'h0});
        chk("wrap.wv3", s_wv, 0);
        chk("wrap.ir3", s_ir, 1);
        chk("wrap.err3", s_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
